// File: rtl/seg_scan_mux_if.sv
// Display-driver bus: captured BCD digits, overflow, load strobe and the
// active-low segment/anode drive returned to the board.
interface seg_scan_mux_if;
    logic [3:0] digit_1;
    logic [3:0] digit_2;
    logic [3:0] digit_3;
    logic       ovf;
    logic       load;
    logic       blank_lz;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;

    modport master (
        output digit_1, digit_2, digit_3, ovf, load, blank_lz,
        input  seg, dp, an
    );

    modport slave (
        input  digit_1, digit_2, digit_3, ovf, load, blank_lz,
        output seg, dp, an
    );
endinterface

// File: rtl/seg_scan_mux.sv
// Time-multiplexed 3-digit common-anode 7-segment driver with per-slot
// anode blanking, optional leading-zero suppression and overflow on the ones dp.
module seg_scan_mux #(
    parameter int unsigned REFRESH_DIV = 100000,
    parameter int unsigned BLANK_CYC   = 1000
) (
    input  logic           clk,
    input  logic           rst_n,
    seg_scan_mux_if.slave  bus
);
    localparam int unsigned CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

    typedef enum logic [1:0] {
        SLOT_ONES  = 2'd0,
        SLOT_TENS  = 2'd1,
        SLOT_HUNDS = 2'd2,
        SLOT_BAD   = 2'd3
    } slot_t;

    slot_t            slot, slot_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [3:0]       cap_h, cap_t, cap_o;
    logic             cap_ovf;

    logic [3:0]       sel_digit;
    logic             in_blank;
    logic             suppress;
    logic [6:0]       seg_code;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cap_h   <= '0;
            cap_t   <= '0;
            cap_o   <= '0;
            cap_ovf <= 1'b0;
            slot    <= SLOT_ONES;
            cnt     <= '0;
        end else begin
            if (bus.load) begin
                cap_h   <= bus.digit_1;
                cap_t   <= bus.digit_2;
                cap_o   <= bus.digit_3;
                cap_ovf <= bus.ovf;
            end
            slot <= slot_nxt;
            cnt  <= cnt_nxt;
        end
    end

    always_comb begin
        slot_nxt = slot;
        cnt_nxt  = cnt + 1'b1;
        if (slot == SLOT_BAD) begin
            slot_nxt = SLOT_ONES;
            cnt_nxt  = '0;
        end else if (cnt == CNT_LAST) begin
            cnt_nxt = '0;
            case (slot)
                SLOT_ONES: slot_nxt = SLOT_TENS;
                SLOT_TENS: slot_nxt = SLOT_HUNDS;
                default:   slot_nxt = SLOT_ONES;
            endcase
        end
    end

    // Only registered state feeds the decode; blank_lz is the one live input.
    always_comb begin
        in_blank  = (32'(cnt) < BLANK_CYC);
        sel_digit = cap_o;
        suppress  = 1'b0;
        case (slot)
            SLOT_TENS: begin
                sel_digit = cap_t;
                suppress  = bus.blank_lz && (cap_h == 4'd0) && (cap_t == 4'd0);
            end
            SLOT_HUNDS: begin
                sel_digit = cap_h;
                suppress  = bus.blank_lz && (cap_h == 4'd0);
            end
            default: ;
        endcase

        case (sel_digit)
            4'd0:    seg_code = 7'b1000000;
            4'd1:    seg_code = 7'b1111001;
            4'd2:    seg_code = 7'b0100100;
            4'd3:    seg_code = 7'b0110000;
            4'd4:    seg_code = 7'b0011001;
            4'd5:    seg_code = 7'b0010010;
            4'd6:    seg_code = 7'b0000010;
            4'd7:    seg_code = 7'b1111000;
            4'd8:    seg_code = 7'b0000000;
            4'd9:    seg_code = 7'b0010000;
            default: seg_code = 7'b1111111;
        endcase

        bus.an  = 4'b1111;
        bus.seg = 7'b1111111;
        bus.dp  = 1'b1;
        if (!in_blank && !suppress) begin
            bus.seg = seg_code;
            case (slot)
                SLOT_ONES: begin
                    bus.an = 4'b1110;
                    bus.dp = ~cap_ovf;
                end
                SLOT_TENS:  bus.an = 4'b1101;
                SLOT_HUNDS: bus.an = 4'b1011;
                default: begin
                    bus.an  = 4'b1111;
                    bus.seg = 7'b1111111;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_seg_scan_mux.sv
// Self-checking bench for seg_scan_mux: directed scenarios followed by random
// traffic, all compared against a time-since-reset display model.
module tb_seg_scan_mux;
    localparam int unsigned RD = 8;
    localparam int unsigned BC = 2;

    logic clk;
    logic rst_n;
    seg_scan_mux_if bus ();

    seg_scan_mux #(.REFRESH_DIV(RD), .BLANK_CYC(BC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int          checks = 0;
    int          errors = 0;
    int unsigned t      = 0;
    logic [3:0]  m_h = '0, m_t = '0, m_o = '0;
    logic        m_ovf = 1'b0;

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        logic [6:0] tbl [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                 7'b0000000, 7'b0010000};
        return (d < 4'd10) ? tbl[d] : 7'b1111111;
    endfunction

    // Expected display derived from elapsed cycles since reset.
    task automatic model_out(output logic [6:0] es, output logic edp, output logic [3:0] ea);
        int unsigned s  = (t / RD) % 3;
        int unsigned ph = t % RD;
        logic [3:0]  d  = (s == 0) ? m_o : (s == 1) ? m_t : m_h;
        logic        sup = bus.blank_lz && ((s == 2 && m_h == 0) || (s == 1 && m_h == 0 && m_t == 0));
        es = 7'b1111111; edp = 1'b1; ea = 4'b1111;
        if (ph >= BC && !sup) begin
            es = seg_of(d);
            ea = 4'b1111 & ~(4'b0001 << s);
            edp = (s == 0) ? ~m_ovf : 1'b1;
        end
    endtask

    task automatic check_outputs(input string tag);
        logic [6:0] es;
        logic       edp;
        logic [3:0] ea;
        model_out(es, edp, ea);
        checks++;
        assert (bus.an === ea) else begin
            errors++;
            $error("FAIL %s an got %b exp %b t=%0d", tag, bus.an, ea, t);
        end
        checks++;
        assert (bus.seg === es) else begin
            errors++;
            $error("FAIL %s seg got %b exp %b t=%0d", tag, bus.seg, es, t);
        end
        checks++;
        assert (bus.dp === edp) else begin
            errors++;
            $error("FAIL %s dp got %b exp %b t=%0d", tag, bus.dp, edp, t);
        end
    endtask

    task automatic step(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            if (!rst_n) begin
                t = 0; m_h = '0; m_t = '0; m_o = '0; m_ovf = 1'b0;
            end else begin
                t++;
                if (bus.load) begin
                    m_h = bus.digit_1; m_t = bus.digit_2; m_o = bus.digit_3; m_ovf = bus.ovf;
                end
            end
            #1;
            check_outputs(tag);
        end
    endtask

    task automatic run_to(input int unsigned frame_pos, input string tag);
        int budget = 3 * RD + 2;
        while ((t % (3 * RD)) != frame_pos && budget > 0) begin
            step(1, tag);
            budget--;
        end
        checks++;
        assert (budget > 0) else begin
            errors++;
            $error("FAIL %s run_to budget got t=%0d exp pos %0d", tag, t, frame_pos);
        end
    endtask

    task automatic load_digits(input logic [3:0] h, input logic [3:0] tn, input logic [3:0] o,
                               input logic v, input string tag);
        bus.digit_1 = h; bus.digit_2 = tn; bus.digit_3 = o; bus.ovf = v; bus.load = 1'b1;
        step(1, tag);
        bus.load = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        bus.digit_1 = '0; bus.digit_2 = '0; bus.digit_3 = '0;
        bus.ovf = 1'b0; bus.load = 1'b0; bus.blank_lz = 1'b0;

        step(3, "reset");
        checks++;
        assert (bus.an === 4'b1111 && bus.seg === 7'b1111111 && bus.dp === 1'b1) else begin
            errors++;
            $error("FAIL reset_const got an=%b seg=%b dp=%b exp 1111/1111111/1", bus.an, bus.seg, bus.dp);
        end

        rst_n = 1'b1;
        step(4, "first_frame");
        checks++;
        assert (bus.an === 4'b1110 && bus.seg === 7'b1000000) else begin
            errors++;
            $error("FAIL ones_zero got an=%b seg=%b exp 1110/1000000", bus.an, bus.seg);
        end
        step(12, "first_frame");

        load_digits(4'd1, 4'd2, 4'd8, 1'b0, "load_128");
        step(48, "digits_128");

        load_digits(4'd0, 4'd0, 4'd7, 1'b0, "load_007");
        bus.blank_lz = 1'b1;
        #1 check_outputs("blz_live");
        step(24, "lz_on_007");
        bus.blank_lz = 1'b0;
        #1 check_outputs("blz_live");
        step(24, "lz_off_007");

        bus.blank_lz = 1'b1;
        load_digits(4'd0, 4'd5, 4'd0, 1'b0, "load_050");
        step(24, "lz_on_050");

        bus.blank_lz = 1'b0;
        load_digits(4'd0, 4'd0, 4'hA, 1'b1, "load_err");
        step(24, "err_ovf");

        load_digits(4'd0, 4'd0, 4'd3, 1'b0, "load_3");
        run_to(3, "mid_slot");
        bus.digit_3 = 4'd9; bus.load = 1'b1;
        step(1, "mid_slot_load");
        checks++;
        assert (bus.an === 4'b1110 && bus.seg === 7'b0010000) else begin
            errors++;
            $error("FAIL mid_slot_9 got an=%b seg=%b exp 1110/0010000", bus.an, bus.seg);
        end
        bus.load = 1'b0;
        step(8, "mid_slot");

        load_digits(4'd3, 4'd4, 4'd5, 1'b0, "load_345");
        run_to(2 * RD + 5, "pre_reset");
        rst_n = 1'b0;
        bus.digit_1 = 4'd9; bus.digit_2 = 4'd9; bus.digit_3 = 4'd9; bus.load = 1'b1;
        step(1, "mid_reset");
        rst_n = 1'b1; bus.load = 1'b0;
        step(24, "post_reset");

        for (int i = 0; i < 1500; i++) begin
            bus.digit_1 = 4'($urandom_range(0, 15));
            bus.digit_2 = 4'($urandom_range(0, 15));
            bus.digit_3 = 4'($urandom_range(0, 15));
            bus.ovf     = 1'($urandom_range(0, 1));
            bus.load    = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 15) == 0) bus.blank_lz = ~bus.blank_lz;
            rst_n = ($urandom_range(0, 99) != 0);
            step(1, "random");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
